// File: rtl/arr_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   DEFAULT_INPUT_BIT_SIZE  : default operand width
//   DEFAULT_OUTPUT_BIT_SIZE : default product width (always twice the operand width)
//   mult_state_e            : controller state encoding (IDLE, BUSY, DONE)
package arr_mult_pkg;

    localparam int DEFAULT_INPUT_BIT_SIZE  = 32;
    localparam int DEFAULT_OUTPUT_BIT_SIZE = 2 * DEFAULT_INPUT_BIT_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: operand registers, shifter, adder, accumulator and the
// registered product.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, clears every register
//   load   : capture in_a/in_b and clear the accumulator (accepted start)
//   step   : perform one shift-add iteration
//   finish : qualifies the final step; the completed sum goes to out
//   in_a   : unsigned multiplicand
//   in_b   : unsigned multiplier
//   out    : registered product, held until the next completed operation
module seq_mult_datapath
    import arr_mult_pkg::*;
#(
    parameter int INPUT_BIT_SIZE  = DEFAULT_INPUT_BIT_SIZE,
    parameter int OUTPUT_BIT_SIZE = 2 * INPUT_BIT_SIZE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       step,
    input  logic                       finish,
    input  logic [INPUT_BIT_SIZE-1:0]  in_a,
    input  logic [INPUT_BIT_SIZE-1:0]  in_b,
    output logic [OUTPUT_BIT_SIZE-1:0] out
);

    logic [OUTPUT_BIT_SIZE-1:0] mcand_r;
    logic [INPUT_BIT_SIZE-1:0]  mplier_r;
    logic [OUTPUT_BIT_SIZE-1:0] acc_r;
    logic [OUTPUT_BIT_SIZE-1:0] out_r;
    logic [OUTPUT_BIT_SIZE-1:0] addend_s;
    logic [OUTPUT_BIT_SIZE-1:0] sum_s;

    // Adder: accumulator plus the shifted multiplicand when the multiplier LSB is set.
    // Both are full product width, so the sum can never overflow.
    always_comb begin
        addend_s = {OUTPUT_BIT_SIZE{1'b0}};
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {OUTPUT_BIT_SIZE{1'b0}};
        end
        sum_s = acc_r + addend_s;
    end

    // Operand and accumulator registers: load on start, shift-add on each step.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= {OUTPUT_BIT_SIZE{1'b0}};
            mplier_r <= {INPUT_BIT_SIZE{1'b0}};
            acc_r    <= {OUTPUT_BIT_SIZE{1'b0}};
        end else if (load) begin
            mcand_r  <= {{(OUTPUT_BIT_SIZE-INPUT_BIT_SIZE){1'b0}}, in_a};
            mplier_r <= in_b;
            acc_r    <= {OUTPUT_BIT_SIZE{1'b0}};
        end else if (step) begin
            mcand_r  <= {mcand_r[OUTPUT_BIT_SIZE-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[INPUT_BIT_SIZE-1:1]};
            acc_r    <= sum_s;
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
        end
    end

    // Product register: takes the sum of the final step directly, so the
    // result appears on the same edge the controller enters DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r <= {OUTPUT_BIT_SIZE{1'b0}};
        end else if (step && finish) begin
            out_r <= sum_s;
        end else begin
            out_r <= out_r;
        end
    end

    assign out = out_r;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier, one shift-add step per clock, fixed latency
// of INPUT_BIT_SIZE cycles from the accepted Start edge to Done.
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset, aborts any operation
//   Start : request; accepted in IDLE or DONE, ignored in BUSY
//   InA   : unsigned multiplicand, captured on an accepted Start
//   InB   : unsigned multiplier, captured on an accepted Start
//   Busy  : high while an operation is in progress
//   Done  : one-cycle pulse when Out carries a new product
//   Out   : registered product
module seq_multiplier
    import arr_mult_pkg::*;
#(
    parameter int INPUT_BIT_SIZE  = DEFAULT_INPUT_BIT_SIZE,
    parameter int OUTPUT_BIT_SIZE = 2 * INPUT_BIT_SIZE
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic [INPUT_BIT_SIZE-1:0]  InA,
    input  logic [INPUT_BIT_SIZE-1:0]  InB,
    output logic                       Busy,
    output logic                       Done,
    output logic [OUTPUT_BIT_SIZE-1:0] Out
);

    // Wide enough to hold INPUT_BIT_SIZE, so the count never wraps mid-operation.
    localparam int CNT_W = $clog2(INPUT_BIT_SIZE + 1);

    mult_state_e      state_r;
    mult_state_e      state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic             step_s;
    logic             last_s;

    assign accept_s = Start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign step_s   = (state_r == ST_BUSY);
    assign last_s   = step_s && (cnt_r == CNT_W'(INPUT_BIT_SIZE - 1));

    // State register; Reset wins over everything, including a coincident Start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DONE can restart directly for back-to-back operation.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state_r)
            ST_BUSY: begin
                Busy = 1'b1;
                Done = 1'b0;
            end
            ST_DONE: begin
                Busy = 1'b0;
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
                Done = 1'b0;
            end
        endcase
    end

    // Iteration counter: cleared on accept, advanced once per BUSY step.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (step_s) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    seq_mult_datapath #(
        .INPUT_BIT_SIZE  (INPUT_BIT_SIZE),
        .OUTPUT_BIT_SIZE (OUTPUT_BIT_SIZE)
    ) u_datapath (
        .clk    (Clk),
        .reset  (Reset),
        .load   (accept_s),
        .step   (step_s),
        .finish (last_s),
        .in_a   (InA),
        .in_b   (InB),
        .out    (Out)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (default 32-bit operands).
module tb_seq_multiplier;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] InA;
    logic [31:0] InB;
    logic        Busy;
    logic        Done;
    logic [63:0] Out;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    seq_multiplier dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .InA   (InA),
        .InB   (InB),
        .Busy  (Busy),
        .Done  (Done),
        .Out   (Out)
    );

    always #5 Clk = ~Clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Issue one operation from the current cycle and wait (bounded) for Done.
    // Returns the number of edges from the Start edge to Done, whether Busy
    // stayed high throughout, and whether Out held its previous value.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ok, output bit out_stable);
        logic [63:0] prev_out;
        prev_out = Out;
        Start = 1'b1;
        InA   = a;
        InB   = b;
        exp_q.push_back(64'(a) * 64'(b));
        @(posedge Clk); #1;
        Start = 1'b0;
        InA   = $urandom;
        InB   = $urandom;
        lat = 0; busy_ok = 1'b1; out_stable = 1'b1;
        while (!Done && lat < 100) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            if (Out !== prev_out) out_stable = 1'b0;
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b1; InA = 32'h0000_0003; InB = 32'h0000_0005;
        @(posedge Clk); #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
        checks++; if (Out !== 64'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", Out); end
        Reset = 1'b0; Start = 1'b0;
        @(posedge Clk); #1;
        // The Start seen together with Reset must not have launched anything.
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_start_discard: busy %b expected 0", Busy); end
    endtask

    task automatic test_basic;
        int lat; bit busy_ok; bit out_stable; logic [63:0] exp;
        run_op(32'h0000_1111, 32'h0000_0111, lat, busy_ok, out_stable);
        checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency: got %0d expected 32", lat); end
        checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL basic_busy: busy dropped during op, expected 1"); end
        checks++; if (out_stable !== 1'b1) begin errors++; $display("FAIL basic_out_hold: out changed during op, expected hold"); end
        checks++;
        if (!Done || exp_q.size() == 0) begin
            errors++; $display("FAIL basic_done: done %b expected 1", Done);
        end else begin
            exp = exp_q.pop_front();
            checks++; if (Out !== exp) begin errors++; $display("FAIL basic_out: got %h expected %h", Out, exp); end
            checks++; if (Out !== 64'h0000_0000_0012_3321) begin errors++; $display("FAIL basic_out_const: got %h expected 0000000000123321", Out); end
        end
        @(posedge Clk); #1;
        checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL basic_idle: done %b busy %b expected 0 0", Done, Busy); end
        checks++; if (Out !== 64'h0000_0000_0012_3321) begin errors++; $display("FAIL basic_idle_hold: got %h expected 0000000000123321", Out); end
    endtask

    task automatic test_edges;
        logic [31:0] a_tab[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001};
        logic [31:0] b_tab[3] = '{32'hFFFF_FFFF, 32'h1000_0111, 32'h8000_0000};
        int lat; bit busy_ok; bit out_stable; logic [63:0] exp;
        for (int i = 0; i < 3; i++) begin
            run_op(a_tab[i], b_tab[i], lat, busy_ok, out_stable);
            checks++; if (lat !== 32) begin errors++; $display("FAIL edge%0d_latency: got %0d expected 32", i, lat); end
            checks++;
            if (!Done || exp_q.size() == 0) begin
                errors++; $display("FAIL edge%0d_done: done %b expected 1", i, Done);
            end else begin
                exp = exp_q.pop_front();
                checks++; if (Out !== exp) begin errors++; $display("FAIL edge%0d_out: got %h expected %h", i, Out, exp); end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_start_held;
        int n; logic [63:0] exp;
        Start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            InA = 32'h0100_1111;
            InB = 32'h1000_0111;
            exp_q.push_back(64'(32'h0100_1111) * 64'(32'h1000_0111));
            @(posedge Clk); #1;
            checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL held%0d_busy: got %b expected 1", op, Busy); end
            n = 0;
            // Operands wander while busy; they must not be re-sampled.
            while (!Done && n < 100) begin
                InA = $urandom;
                InB = $urandom;
                @(posedge Clk); #1;
                n++;
            end
            checks++; if (n !== 32) begin errors++; $display("FAIL held%0d_latency: got %0d expected 32", op, n); end
            checks++;
            if (!Done || exp_q.size() == 0) begin
                errors++; $display("FAIL held%0d_done: done %b expected 1", op, Done);
            end else begin
                exp = exp_q.pop_front();
                checks++; if (Out !== exp) begin errors++; $display("FAIL held%0d_out: got %h expected %h", op, Out, exp); end
            end
        end
        Start = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_abort;
        int lat; bit busy_ok; bit out_stable; int seen_done; logic [63:0] exp;
        Start = 1'b1; InA = 32'h0000_1111; InB = 32'h0000_0111;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (10) begin @(posedge Clk); #1; end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", Busy); end
        checks++; if (Out !== 64'h0) begin errors++; $display("FAIL abort_out: got %h expected 0", Out); end
        seen_done = 0;
        repeat (40) begin
            if (Done !== 1'b0) seen_done++;
            @(posedge Clk); #1;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done cycles expected 0", seen_done); end
        run_op(32'd3, 32'd5, lat, busy_ok, out_stable);
        checks++; if (lat !== 32) begin errors++; $display("FAIL abort_next_latency: got %0d expected 32", lat); end
        checks++;
        if (!Done || exp_q.size() == 0) begin
            errors++; $display("FAIL abort_next_done: done %b expected 1", Done);
        end else begin
            exp = exp_q.pop_front();
            checks++; if (Out !== exp) begin errors++; $display("FAIL abort_next_out: got %h expected %h", Out, exp); end
            checks++; if (Out !== 64'hF) begin errors++; $display("FAIL abort_next_const: got %h expected f", Out); end
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat; bit busy_ok; bit out_stable; logic [63:0] exp;
        run_op(32'h0000_1111, 32'h0000_0111, lat, busy_ok, out_stable);
        checks++;
        if (!Done || exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_first_done: done %b expected 1", Done);
        end else begin
            exp = exp_q.pop_front();
            checks++; if (Out !== exp) begin errors++; $display("FAIL b2b_first_out: got %h expected %h", Out, exp); end
        end
        // Start issued during the DONE cycle must launch without a bubble.
        run_op(32'h1100_1111, 32'h1000_0011, lat, busy_ok, out_stable);
        checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL b2b_busy: busy not continuous after restart, expected 1"); end
        checks++; if (out_stable !== 1'b1) begin errors++; $display("FAIL b2b_out_hold: out changed while busy, expected hold"); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", lat); end
        checks++;
        if (!Done || exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_second_done: done %b expected 1", Done);
        end else begin
            exp = exp_q.pop_front();
            checks++; if (Out !== exp) begin errors++; $display("FAIL b2b_second_out: got %h expected %h", Out, exp); end
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; InA = 32'h0; InB = 32'h0;
        @(posedge Clk); #1;
        test_reset();
        test_basic();
        test_edges();
        test_start_held();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
